// File: rtl/iob_native_mem_responder_pkg.sv
// Shared types for the IOb-native memory responder.
//   state_t      - FSM state encoding, also visible on the debug state output
//   CNT_W        - width of the shared wait-state / read-latency down-counter
//   state_ready  - ready as a pure function of the FSM state
package iob_native_mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // nothing in flight
    ST_WAIT = 3'd1,  // burning wait states before the first acceptance
    ST_ACC  = 3'd2,  // wait states done, ready to accept
    ST_BUSY = 3'd3,  // read accepted, extra latency still running
    ST_RESP = 3'd4,  // rvalid cycle, may accept the next request
    ST_WACK = 3'd5   // write-completion cycle, may accept the next request
  } state_t;

  // Wide enough for WAIT_ST-1 (max 14) and READ_LAT-2 (max 2).
  localparam int CNT_W = 4;

  // ready never looks at the request, so the initiator cannot build a comb loop.
  function automatic logic state_ready(input state_t st, input logic no_wait);
    logic rdy;
    case (st)
      ST_IDLE:                 rdy = no_wait;
      ST_ACC, ST_RESP, ST_WACK: rdy = 1'b1;
      default:                 rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/iob_native_mem_responder_ram.sv
// Single-port byte-enabled RAM with a one-cycle synchronous read.
//   clk_i  - clock
//   en_i   - access enable (write or read this edge)
//   we_i   - 1: write bytes selected by be_i, 0: read
//   be_i   - byte enables
//   addr_i - word address
//   d_i    - write data
//   d_o    - read data, registered; holds the last read until the next read
// Contents are never cleared, so data survives a responder reset.
module iob_native_mem_responder_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     d_i,
  output logic [DATA_W-1:0]     d_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
        end
      end else begin
        rd_q <= mem_q[addr_i];
      end
    end
  end

  assign d_o = rd_q;

endmodule

// File: rtl/iob_native_mem_responder.sv
// IOb-native responder: target end of a CPU ibus/dbus port backed by an internal RAM.
//   clk_i       - clock
//   rst_i       - asynchronous active-high reset
//   cke_i       - clock enable; low freezes state, counters, RAM and outputs
//   req         - packed request {avalid, address, wdata, wstrb}
//   resp        - packed response {rdata, rvalid, ready}
//   dbg_state_o - current FSM state (state_t encoding)
//
// Handshake: a request is accepted on a rising edge where avalid & ready & cke_i.
// ready depends only on the FSM state. The initiator holds the request stable
// until it is accepted. Non-zero wstrb means write, zero means read. rvalid
// pulses for one cycle exactly READ_LAT cycles after a read is accepted; writes
// get no rvalid, only a one-cycle ready (WACK) after acceptance.
module iob_native_mem_responder
  import iob_native_mem_responder_pkg::*;
#(
  parameter int  ADDR_W     = 32,
  parameter int  DATA_W     = 32,
  parameter int  MEM_ADDR_W = 12,
  parameter int  WAIT_ST    = 0,
  parameter int  READ_LAT   = 1,
  localparam int WSTRB_W    = DATA_W / 8,
  localparam int REQ_W      = 1 + ADDR_W + DATA_W + WSTRB_W,
  localparam int RESP_W     = DATA_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp,
  output logic [2:0]        dbg_state_o
);

  localparam int               WORD_AW   = MEM_ADDR_W - 2;
  localparam logic             NO_WAIT   = (WAIT_ST == 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT_ST > 0) ? CNT_W'(WAIT_ST - 1) : '0;
  // The RAM's own read register supplies one cycle of latency; the counter covers the rest.
  localparam logic [CNT_W-1:0] LAT_INIT  = (READ_LAT > 1) ? CNT_W'(READ_LAT - 2) : '0;

  // Request fields
  logic               avalid;
  logic [ADDR_W-1:0]  address;
  logic [DATA_W-1:0]  wdata;
  logic [WSTRB_W-1:0] wstrb;

  assign {avalid, address, wdata, wstrb} = req;

  // Byte offset and bits above the RAM size are ignored: addresses alias modulo RAM size.
  logic addr_unused;
  assign addr_unused = ^{address[ADDR_W-1:MEM_ADDR_W], address[1:0]};

  // FSM and datapath state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ready;
  logic              accept;
  logic              is_write;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ready    = state_ready(state_q, NO_WAIT);
    accept   = avalid & ready & cke_i;
    is_write = |wstrb;

    if (cke_i) begin
      case (state_q)
        ST_IDLE: begin
          if (avalid && !NO_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_ACC;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_ACC: begin
          if (!avalid) state_d = ST_IDLE;
        end
        ST_BUSY: begin
          if (cnt_q == '0) state_d = ST_RESP;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_RESP, ST_WACK: begin
          if (!avalid) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // Keep the value shown during the rvalid cycle once the RESP cycle ends.
      if (state_q == ST_RESP) rdata_d = ram_rdata;

      // Acceptance overrides the plain next-state choice above; from RESP/WACK
      // this is the back-to-back path that skips wait states.
      if (accept) begin
        ram_en = 1'b1;
        if (is_write) begin
          ram_we  = 1'b1;
          state_d = ST_WACK;
        end else if (READ_LAT == 1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = LAT_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  iob_native_mem_responder_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (WORD_AW)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .be_i   (wstrb),
    .addr_i (address[MEM_ADDR_W-1:2]),
    .d_i    (wdata),
    .d_o    (ram_rdata)
  );

  // During RESP the RAM read register carries the fresh word; elsewhere the
  // held copy is shown, so reset, writes and pending reads never disturb rdata.
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  assign rvalid      = (state_q == ST_RESP);
  assign rdata       = rvalid ? ram_rdata : rdata_q;
  assign resp        = {rdata, rvalid, ready};
  assign dbg_state_o = state_q;

endmodule
